conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming sliding-window generator that feeds the convolution MAC array. It accepts one unsigned feature-map pixel per cycle in raster order, buffers K-1 image rows in on-chip line buffers, and emits one complete KERNEL_SIZE×KERNEL_SIZE window for every valid (unpadded, stride-1) convolution position. Output windows are presented with a valid/ready handshake and are consumed directly as the `feature` operand of the MAC stage.

## Interface
- KERNEL_SIZE, 3: window edge; supported values 3 or 5
- DATA_WIDTH, 8: pixel width, unsigned
- IMG_WIDTH, 28: pixels per row; must be ≥ KERNEL_SIZE
- IMG_HEIGHT, 28: rows per frame; must be ≥ KERNEL_SIZE
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- pix_in  input  DATA_WIDTH  incoming pixel, raster order (row-major, top-left first)
- pix_valid  input  1  pix_in is valid
- pix_ready  output  1  block accepts pix_in this cycle
- window  output  DATA_WIDTH × [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1]  current window; [r][c], r=0 top row, c=0 leftmost column
- win_valid  output  1  window holds a complete convolution window
- win_ready  input  1  downstream consumes window this cycle
- win_last  output  1  qualified by win_valid; final window of the frame

## Operation
- Accept: pixel accepted when pix_valid && pix_ready. pix_ready = !win_valid || win_ready (combinational).
- Position counters col (0..IMG_WIDTH-1), row (0..IMG_HEIGHT-1) track the accepted pixel; col increments per accept, wraps to 0 and increments row; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0, so the next pixel starts a new frame. No frame-start signal.
- Storage: K-1 line buffers of IMG_WIDTH entries, indexed by col. On accept at column col: line buffer k outputs its stored pixel at col (tap k = pixel from row-(K-1-k)); buffers shift upward (lb[k][col] <= lb[k+1][col], last buffer <= pix_in).
- Window register: K×K shift register. On accept, every row shifts left by one column (window[r][c] <= window[r][c+1]); new rightmost column window[0..K-2][K-1] <= line-buffer taps, window[K-1][K-1] <= pix_in.
- Window completion: accept at (row, col) with row ≥ K-1 and col ≥ K-1 completes the window covering rows row-K+1..row, cols col-K+1..col.
- win_valid next state: 1 if completing accept this cycle; else 0 if win_ready; else hold.
- win_last set with win_valid when completing accept is at (IMG_HEIGHT-1, IMG_WIDTH-1); cleared otherwise.
- Windows per frame: (IMG_HEIGHT-K+1)·(IMG_WIDTH-K+1); 676 for defaults.
- Windows straddling a row wrap (col < K-1) are never flagged valid; their stale left columns are don't-care.
- Line buffers are not cleared on reset; stale contents never reach a valid window because validity requires row ≥ K-1.

## Timing
- Reset values: win_valid 0, win_last 0, window all 0, row 0, col 0; pix_ready 1 after reset (win_valid 0).
- Latency: completing pixel accepted in cycle N → win_valid=1 with that window in cycle N+1.
- Throughput: one pixel/cycle and one window/cycle when win_ready held high; no bubbles at row wrap or frame wrap.
- Stall: while win_valid && !win_ready, pix_ready=0; window, win_valid, win_last, counters, line buffers all hold stable.
- Simultaneous consume + completing accept: win_valid stays 1, window updates to the new window the next cycle.
- Consume + non-completing accept: win_valid falls to 0 next cycle.
- Reset mid-frame: all counters/outputs return to reset values immediately (async); next accepted pixel is treated as (0,0) of a new frame.

## Test plan
- Ramp frame, defaults, pix_in = (row·28+col) mod 256, pix_valid and win_ready always 1 → first win_valid one cycle after pixel (2,2); window rows {0,1,2},{28,29,30},{56,57,58}; exactly 676 windows; win_last only on window ending at (27,27).
- Same frame, count row-wrap behaviour → no win_valid following pixels at col 0 or 1 of any row; window after pixel (3,2) is {28,29,30},{56,57,58},{84,85,86}.
- win_ready toggled 1-of-3 cycles, random pix_valid gaps → identical ordered window sequence to unstalled run; pix_ready=0 and window stable during every stall.
- Two back-to-back frames (second frame pix_in = 255 − first) → second frame's first window contains only second-frame pixels {255,254,253},{227,226,225},{199,198,197}; 1352 windows total, two win_last pulses.
- rst asserted mid-frame at pixel (10,15) for 2 cycles, then full new frame → win_valid drops asynchronously; new frame yields exactly 676 correct windows with no stale data.
- KERNEL_SIZE=5, IMG_WIDTH=IMG_HEIGHT=8, ramp pix_in=row·8+col → 16 windows; first window row 0 = {0..4}, row 4 = {32..36}; last window window[4][4]=63 with win_last=1.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen
// Streaming KxK sliding-window generator for the convolution MAC stage.
// Pixels arrive one per cycle in raster order. K-1 line buffers hold the
// previous rows, and a KxK shift register assembles each window. One window
// is presented for every valid stride-1, unpadded convolution position.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   pix_in     incoming pixel (unsigned, raster order)
//   pix_valid  pix_in is valid
//   pix_ready  pixel accepted this cycle (combinational)
//   window     current window [r][c], r=0 is the top row, c=0 is the leftmost column
//   win_valid  window holds a complete convolution window
//   win_ready  downstream consumes the window this cycle
//   win_last   final window of the frame (qualified by win_valid)
module conv_window_gen #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned IMG_WIDTH   = 28,
    parameter int unsigned IMG_HEIGHT  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] window [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  win_last
);

    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned NLB   = KERNEL_SIZE - 1;

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [DATA_WIDTH-1:0] r_lb  [0:NLB-1][0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_win [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic                  r_win_valid;
    logic                  r_win_last;

    logic                  w_accept;
    logic                  w_col_end;
    logic                  w_row_end;
    logic                  w_complete;
    logic                  w_frame_end;
    logic [DATA_WIDTH-1:0] w_tap [0:NLB-1];

    // Backpressure: a pending window that is not being consumed blocks input.
    assign pix_ready   = !r_win_valid || win_ready;
    assign w_accept    = pix_valid && pix_ready;
    assign w_col_end   = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_end   = (r_row == ROW_W'(IMG_HEIGHT - 1));
    assign w_frame_end = w_col_end && w_row_end;
    // Only positions whose window lies fully inside the frame complete a window.
    assign w_complete  = w_accept
                       && (r_row >= ROW_W'(KERNEL_SIZE - 1))
                       && (r_col >= COL_W'(KERNEL_SIZE - 1));

    // Raster position of the pixel being accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Line-buffer taps at the current column; tap k is the pixel from row-(K-1-k).
    always_comb begin
        for (int k = 0; k < NLB; k++) begin
            w_tap[k] = r_lb[k][r_col];
        end
    end

    // Line buffers shift upward by one row at the accepted column. They are not
    // reset: stale rows never reach a valid window.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NLB - 1; k++) begin
                r_lb[k][r_col] <= r_lb[k+1][r_col];
            end
            r_lb[NLB-1][r_col] <= pix_in;
        end
    end

    // Window shift register: shift left, load the new rightmost column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
            end
            for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
                r_win[r][KERNEL_SIZE-1] <= w_tap[r];
            end
            r_win[KERNEL_SIZE-1][KERNEL_SIZE-1] <= pix_in;
        end
    end

    // Output handshake: set on completion, cleared on consume, held on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_complete) begin
            r_win_valid <= 1'b1;
            r_win_last  <= w_frame_end;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end
    end

    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;

    for (genvar gr = 0; gr < KERNEL_SIZE; gr++) begin : g_win_row
        for (genvar gc = 0; gc < KERNEL_SIZE; gc++) begin : g_win_col
            assign window[gr][gc] = r_win[gr][gc];
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: default 3x3 / 28x28 instance plus a
// 5x5 / 8x8 instance. Expected windows are computed from the pixel pattern.
module tb_conv_window_gen;

    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int FR   = W * H;
    localparam int NWIN = (H - K + 1) * (W - K + 1);
    localparam int K5   = 5;
    localparam int W5   = 8;

    typedef struct packed {
        logic [K*K*DW-1:0] w;
        logic              last;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic [DW-1:0] pix_in_a    = '0;
    logic          pix_valid_a = 1'b0;
    logic          pix_ready_a;
    logic [DW-1:0] window_a [0:K-1][0:K-1];
    logic          win_valid_a;
    logic          win_ready_a = 1'b1;
    logic          win_last_a;

    // 5x5 / 8x8 instance
    logic [DW-1:0] pix_in_b    = '0;
    logic          pix_valid_b = 1'b0;
    logic          pix_ready_b;
    logic [DW-1:0] window_b [0:K5-1][0:K5-1];
    logic          win_valid_b;
    logic          win_ready_b = 1'b1;
    logic          win_last_b;

    conv_window_gen u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in_a),
        .pix_valid (pix_valid_a),
        .pix_ready (pix_ready_a),
        .window    (window_a),
        .win_valid (win_valid_a),
        .win_ready (win_ready_a),
        .win_last  (win_last_a)
    );

    conv_window_gen #(
        .KERNEL_SIZE (K5),
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (W5),
        .IMG_HEIGHT  (W5)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in_b),
        .pix_valid (pix_valid_b),
        .pix_ready (pix_ready_b),
        .window    (window_b),
        .win_valid (win_valid_b),
        .win_ready (win_ready_b),
        .win_last  (win_last_b)
    );

    int   total = 0;
    int   bad   = 0;
    win_t cap_q[$];
    int   stall_err, wrap_err, stall_seen, first_acc;
    bit   timed_out;

    // Pixel value: ramp for even frames, inverted ramp for odd frames.
    function automatic logic [DW-1:0] pv(int f, int r, int c);
        int v;
        v = (r * W + c) % 256;
        return (f % 2 == 1) ? DW'(255 - v) : DW'(v);
    endfunction

    function automatic logic [K*K*DW-1:0] exp_win(int f, int r, int c);
        logic [K*K*DW-1:0] e;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                e[(i*K+j)*DW +: DW] = pv(f, r - K + 1 + i, c - K + 1 + j);
        return e;
    endfunction

    // i-th window of a stream that starts at a frame boundary.
    function automatic win_t exp_entry(int i);
        win_t e;
        int   f, j;
        f      = i / NWIN;
        j      = i % NWIN;
        e.w    = exp_win(f, K - 1 + j / (W - K + 1), K - 1 + j % (W - K + 1));
        e.last = (j == NWIN - 1);
        return e;
    endfunction

    function automatic logic [3*DW-1:0] row3(int a, int b, int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [K*K*DW-1:0] flat_a();
        logic [K*K*DW-1:0] v;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                v[(i*K+j)*DW +: DW] = window_a[i][j];
        return v;
    endfunction

    function automatic logic [K5*K5*DW-1:0] flat_b();
        logic [K5*K5*DW-1:0] v;
        for (int i = 0; i < K5; i++)
            for (int j = 0; j < K5; j++)
                v[(i*K5+j)*DW +: DW] = window_b[i][j];
        return v;
    endfunction

    // Drive npix pixels into instance A, capture consumed windows, and tally
    // stall-stability and row-wrap violations. Called at posedge+1.
    task automatic stream(input int npix, input bit stall);
        int                acc, cyc, limit, acc_col;
        bit                was_stall, acc_now, snap_last;
        logic [K*K*DW-1:0] snap;
        win_t              e;
        cap_q.delete();
        stall_err = 0; wrap_err = 0; stall_seen = 0; first_acc = -1; timed_out = 0;
        acc = 0; cyc = 0; limit = npix * 6 + 50;
        snap = '0; snap_last = 1'b0;
        while ((acc < npix || win_valid_a === 1'b1) && cyc < limit) begin
            win_ready_a = stall ? (cyc % 3 == 0) : 1'b1;
            pix_valid_a = (acc < npix) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            pix_in_a    = pv(acc / FR, (acc % FR) / W, acc % W);
            #1;
            was_stall = win_valid_a && !win_ready_a;
            if (was_stall) begin
                stall_seen++;
                if (pix_ready_a !== 1'b0) stall_err++;
                snap      = flat_a();
                snap_last = win_last_a;
            end
            if (win_valid_a && win_ready_a) begin
                e.w    = flat_a();
                e.last = win_last_a;
                cap_q.push_back(e);
            end
            acc_now = pix_valid_a && pix_ready_a;
            acc_col = acc % W;
            if (acc_now) acc++;
            @(posedge clk); #1;
            cyc++;
            if (was_stall && (win_valid_a !== 1'b1 || flat_a() !== snap || win_last_a !== snap_last))
                stall_err++;
            if (acc_now && acc_col < K - 1 && win_valid_a !== 1'b0) wrap_err++;
            if (first_acc < 0 && win_valid_a === 1'b1) first_acc = acc;
        end
        pix_valid_a = 1'b0;
        win_ready_a = 1'b1;
        timed_out   = (cyc >= limit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (win_valid_a !== 1'b0) begin bad++; $display("FAIL reset_win_valid: got %b want 0", win_valid_a); end
        total++;
        if (win_last_a !== 1'b0) begin bad++; $display("FAIL reset_win_last: got %b want 0", win_last_a); end
        total++;
        if (pix_ready_a !== 1'b1) begin bad++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready_a); end
        total++;
        if (flat_a() !== '0) begin bad++; $display("FAIL reset_window: got %h want 0", flat_a()); end
        total++;
        if (win_valid_b !== 1'b0) begin bad++; $display("FAIL reset_win_valid_k5: got %b want 0", win_valid_b); end
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        win_t e;
        stream(FR, 1'b0);
        total++;
        if (timed_out) begin bad++; $display("FAIL ramp_timeout: got 1 want 0"); end
        total++;
        if (cap_q.size() != NWIN) begin bad++; $display("FAIL ramp_count: got %0d want %0d", cap_q.size(), NWIN); end
        total++;
        if (first_acc != 2 * W + 3) begin bad++; $display("FAIL ramp_first_latency: got %0d want %0d", first_acc, 2 * W + 3); end
        total++;
        if (wrap_err != 0) begin bad++; $display("FAIL ramp_row_wrap: got %0d want 0", wrap_err); end
        if (cap_q.size() > 26) begin
            e = cap_q[0];
            total++;
            if (e.w !== {row3(56, 57, 58), row3(28, 29, 30), row3(0, 1, 2)}) begin
                bad++; $display("FAIL ramp_first_window: got %h want %h", e.w, {row3(56, 57, 58), row3(28, 29, 30), row3(0, 1, 2)});
            end
            e = cap_q[26];
            total++;
            if (e.w !== {row3(84, 85, 86), row3(56, 57, 58), row3(28, 29, 30)}) begin
                bad++; $display("FAIL ramp_wrap_window: got %h want %h", e.w, {row3(84, 85, 86), row3(56, 57, 58), row3(28, 29, 30)});
            end
        end
        for (int i = 0; i < cap_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_entry(i)) begin
                bad++; $display("FAIL ramp_win[%0d]: got %h want %h", i, cap_q[i], exp_entry(i));
            end
        end
    endtask

    task automatic test_stall();
        stream(FR, 1'b1);
        total++;
        if (timed_out) begin bad++; $display("FAIL stall_timeout: got 1 want 0"); end
        total++;
        if (cap_q.size() != NWIN) begin bad++; $display("FAIL stall_count: got %0d want %0d", cap_q.size(), NWIN); end
        total++;
        if (stall_seen < 100) begin bad++; $display("FAIL stall_seen: got %0d want >=100", stall_seen); end
        total++;
        if (stall_err != 0) begin bad++; $display("FAIL stall_stability: got %0d want 0", stall_err); end
        total++;
        if (wrap_err != 0) begin bad++; $display("FAIL stall_row_wrap: got %0d want 0", wrap_err); end
        for (int i = 0; i < cap_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_entry(i)) begin
                bad++; $display("FAIL stall_win[%0d]: got %h want %h", i, cap_q[i], exp_entry(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int   nlast;
        win_t e;
        stream(2 * FR, 1'b0);
        nlast = 0;
        total++;
        if (timed_out) begin bad++; $display("FAIL b2b_timeout: got 1 want 0"); end
        total++;
        if (cap_q.size() != 2 * NWIN) begin bad++; $display("FAIL b2b_count: got %0d want %0d", cap_q.size(), 2 * NWIN); end
        if (cap_q.size() > NWIN) begin
            e = cap_q[NWIN];
            total++;
            if (e.w !== {row3(199, 198, 197), row3(227, 226, 225), row3(255, 254, 253)}) begin
                bad++; $display("FAIL b2b_second_first: got %h want %h", e.w, {row3(199, 198, 197), row3(227, 226, 225), row3(255, 254, 253)});
            end
        end
        for (int i = 0; i < cap_q.size(); i++) begin
            e = cap_q[i];
            if (e.last) nlast++;
            total++;
            if (e !== exp_entry(i)) begin
                bad++; $display("FAIL b2b_win[%0d]: got %h want %h", i, e, exp_entry(i));
            end
        end
        total++;
        if (nlast != 2) begin bad++; $display("FAIL b2b_last_pulses: got %0d want 2", nlast); end
    endtask

    task automatic test_reset_mid_frame();
        stream(10 * W + 15, 1'b0);
        // Accept pixel (10,15) and hold the resulting window with win_ready low.
        win_ready_a = 1'b0;
        pix_valid_a = 1'b1;
        pix_in_a    = pv(0, 10, 15);
        @(posedge clk); #1;
        pix_valid_a = 1'b0;
        total++;
        if (win_valid_a !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %b want 1", win_valid_a); end
        total++;
        if (flat_a() !== exp_win(0, 10, 15)) begin bad++; $display("FAIL midrst_pre_window: got %h want %h", flat_a(), exp_win(0, 10, 15)); end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (win_valid_a !== 1'b0) begin bad++; $display("FAIL midrst_async_valid: got %b want 0", win_valid_a); end
        total++;
        if (pix_ready_a !== 1'b1) begin bad++; $display("FAIL midrst_pix_ready: got %b want 1", pix_ready_a); end
        total++;
        if (flat_a() !== '0) begin bad++; $display("FAIL midrst_window: got %h want 0", flat_a()); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        win_ready_a = 1'b1;
        stream(FR, 1'b0);
        total++;
        if (cap_q.size() != NWIN) begin bad++; $display("FAIL midrst_count: got %0d want %0d", cap_q.size(), NWIN); end
        for (int i = 0; i < cap_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_entry(i)) begin
                bad++; $display("FAIL midrst_win[%0d]: got %h want %h", i, cap_q[i], exp_entry(i));
            end
        end
    endtask

    task automatic test_k5();
        logic [K5*K5*DW-1:0] kq[$];
        logic                klq[$];
        logic [K5*K5*DW-1:0] e, v;
        int                  acc, cyc, r, c;
        acc = 0; cyc = 0;
        win_ready_b = 1'b1;
        while ((acc < W5 * W5 || win_valid_b === 1'b1) && cyc < 500) begin
            pix_valid_b = (acc < W5 * W5);
            pix_in_b    = DW'(acc);
            #1;
            if (win_valid_b && win_ready_b) begin
                kq.push_back(flat_b());
                klq.push_back(win_last_b);
            end
            if (pix_valid_b && pix_ready_b) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        pix_valid_b = 1'b0;
        total++;
        if (cyc >= 500) begin bad++; $display("FAIL k5_timeout: got %0d want <500", cyc); end
        total++;
        if (kq.size() != 16) begin bad++; $display("FAIL k5_count: got %0d want 16", kq.size()); end
        if (kq.size() == 16) begin
            v = kq[0];
            total++;
            if (v[39:0] !== {8'd4, 8'd3, 8'd2, 8'd1, 8'd0}) begin bad++; $display("FAIL k5_first_row0: got %h want 0403020100", v[39:0]); end
            total++;
            if (v[199:160] !== {8'd36, 8'd35, 8'd34, 8'd33, 8'd32}) begin bad++; $display("FAIL k5_first_row4: got %h want 2423222120", v[199:160]); end
            v = kq[15];
            total++;
            if (v[199:192] !== 8'd63 || klq[15] !== 1'b1) begin
                bad++; $display("FAIL k5_last: got pix %0d last %b want pix 63 last 1", v[199:192], klq[15]);
            end
        end
        for (int n = 0; n < kq.size(); n++) begin
            r = K5 - 1 + n / (W5 - K5 + 1);
            c = K5 - 1 + n % (W5 - K5 + 1);
            for (int i = 0; i < K5; i++)
                for (int j = 0; j < K5; j++)
                    e[(i*K5+j)*DW +: DW] = DW'((r - K5 + 1 + i) * W5 + (c - K5 + 1 + j));
            total++;
            if (kq[n] !== e || klq[n] !== (n == 15)) begin
                bad++; $display("FAIL k5_win[%0d]: got %h/%b want %h/%b", n, kq[n], klq[n], e, (n == 15));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_k5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
